// File: rtl/memory_access.sv
// Memory-access pipeline stage: issues data-memory requests, aligns load data and drives write-back.
// Optional MISALIGN_TRAP_EN traps misaligned half/word accesses instead of issuing them.
module memory_access #(
    parameter int MAX_WAIT = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [31:0] in_pc,
    input  logic [31:0] in_alu_result,
    input  logic [31:0] in_w_data,
    input  logic [1:0]  in_width,
    input  logic [4:0]  in_rd_addr,
    input  logic        in_w_enable,
    input  logic        in_is_store,
    input  logic        in_is_load,
    input  logic        in_is_load_unsigned,
    output logic        stall,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        wb_valid,
    output logic [31:0] wb_pc,
    output logic [4:0]  wb_rd_addr,
    output logic [31:0] wb_data,
    output logic        wb_w_enable,
    output logic        bus_err,
    output logic        misalign
);
    localparam int CNT_W = $clog2(MAX_WAIT + 1);

    typedef enum logic {ST_IDLE, ST_WAIT} state_t;
    state_t state_reg, state_next;

    logic [CNT_W-1:0] wait_cnt_reg;
    logic [31:0] op_pc_reg;
    logic [4:0]  op_rd_reg;
    logic [1:0]  op_width_reg, op_off_reg;
    logic        op_unsigned_reg, op_w_enable_reg;
    logic        dmem_we_reg;
    logic [31:0] dmem_addr_reg, dmem_wdata_reg;
    logic [3:0]  dmem_be_reg;
    logic        wb_valid_reg, wb_w_enable_reg, bus_err_reg, misalign_reg;
    logic [31:0] wb_pc_reg, wb_data_reg;
    logic [4:0]  wb_rd_reg;

    logic        mem_op, misaligned, trap, timeout_hit;
    logic [1:0]  off, eff_off;
    logic [3:0]  be_next;
    logic [31:0] wdata_next, shifted, load_data;

    assign mem_op = in_valid & (in_is_load | in_is_store);
    assign off    = in_alu_result[1:0];

    // Half accesses only honour the upper offset bit, words always sit at lane 0.
    always_comb begin
        eff_off = 2'd0;
        case (in_width)
            2'd0:    eff_off = off;
            2'd1:    eff_off = {off[1], 1'b0};
            default: eff_off = 2'd0;
        endcase
    end

`ifdef MISALIGN_TRAP_EN
    assign misaligned = ((in_width == 2'd1) && off[0]) || (in_width[1] && (off != 2'd0));
`else
    assign misaligned = 1'b0;
`endif
    assign trap        = mem_op & misaligned;
    assign timeout_hit = (wait_cnt_reg == CNT_W'(MAX_WAIT));

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            always_comb begin
                be_next[gi]             = 1'b1;
                wdata_next[8*gi +: 8]   = in_w_data[8*gi +: 8];
                if (in_width == 2'd0) begin
                    be_next[gi]           = (eff_off == 2'(gi));
                    wdata_next[8*gi +: 8] = in_w_data[7:0];
                end else if (in_width == 2'd1) begin
                    be_next[gi]           = (eff_off[1] == 1'(gi / 2));
                    wdata_next[8*gi +: 8] = in_w_data[8*(gi % 2) +: 8];
                end
            end
        end
    endgenerate

    assign shifted = dmem_rdata >> {op_off_reg, 3'b000};

    always_comb begin
        load_data = dmem_rdata;
        case (op_width_reg)
            2'd0: load_data = op_unsigned_reg ? {24'd0, shifted[7:0]}
                                              : {{24{shifted[7]}}, shifted[7:0]};
            2'd1: load_data = op_unsigned_reg ? {16'd0, shifted[15:0]}
                                              : {{16{shifted[15]}}, shifted[15:0]};
            default: load_data = dmem_rdata;
        endcase
    end

    always_ff @(negedge clk or negedge rst) begin
        if (!rst) state_reg <= ST_IDLE;
        else      state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (mem_op && !trap)           state_next = ST_WAIT;
            ST_WAIT: if (dmem_ack || timeout_hit)   state_next = ST_IDLE;
            default:                                state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        dmem_req = (state_reg == ST_WAIT);
        stall    = 1'b0;
        if (rst) begin
            if (state_reg == ST_IDLE) stall = mem_op & ~trap;
            else                      stall = ~dmem_ack & ~timeout_hit;
        end
    end

    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            wait_cnt_reg    <= '0;
            op_pc_reg       <= '0;
            op_rd_reg       <= '0;
            op_width_reg    <= '0;
            op_off_reg      <= '0;
            op_unsigned_reg <= 1'b0;
            op_w_enable_reg <= 1'b0;
            dmem_we_reg     <= 1'b0;
            dmem_addr_reg   <= '0;
            dmem_be_reg     <= '0;
            dmem_wdata_reg  <= '0;
            wb_valid_reg    <= 1'b0;
            wb_pc_reg       <= '0;
            wb_rd_reg       <= '0;
            wb_data_reg     <= '0;
            wb_w_enable_reg <= 1'b0;
            bus_err_reg     <= 1'b0;
            misalign_reg    <= 1'b0;
        end else begin
            bus_err_reg  <= 1'b0;
            misalign_reg <= 1'b0;
            if (state_reg == ST_IDLE) begin
                if (mem_op && !trap) begin
                    dmem_addr_reg   <= {in_alu_result[31:2], 2'b00};
                    dmem_be_reg     <= be_next;
                    dmem_wdata_reg  <= wdata_next;
                    dmem_we_reg     <= in_is_store;
                    op_pc_reg       <= in_pc;
                    op_rd_reg       <= in_rd_addr;
                    op_width_reg    <= in_width;
                    op_off_reg      <= eff_off;
                    op_unsigned_reg <= in_is_load_unsigned;
                    op_w_enable_reg <= in_w_enable;
                    wait_cnt_reg    <= '0;
                    wb_valid_reg    <= 1'b0;
                    wb_w_enable_reg <= 1'b0;
                end else if (trap) begin
                    misalign_reg    <= 1'b1;
                    wb_valid_reg    <= 1'b1;
                    wb_w_enable_reg <= 1'b0;
                    wb_data_reg     <= '0;
                    wb_pc_reg       <= in_pc;
                    wb_rd_reg       <= in_rd_addr;
                end else begin
                    wb_valid_reg    <= in_valid;
                    wb_w_enable_reg <= in_w_enable & in_valid;
                    wb_data_reg     <= in_alu_result;
                    wb_pc_reg       <= in_pc;
                    wb_rd_reg       <= in_rd_addr;
                end
            end else begin
                if (dmem_ack) begin
                    wb_valid_reg    <= 1'b1;
                    wb_w_enable_reg <= dmem_we_reg ? 1'b0 : op_w_enable_reg;
                    wb_data_reg     <= dmem_we_reg ? 32'd0 : load_data;
                    wb_pc_reg       <= op_pc_reg;
                    wb_rd_reg       <= op_rd_reg;
                    wait_cnt_reg    <= '0;
                end else if (timeout_hit) begin
                    bus_err_reg     <= 1'b1;
                    wb_valid_reg    <= 1'b1;
                    wb_w_enable_reg <= 1'b0;
                    wb_data_reg     <= '0;
                    wb_pc_reg       <= op_pc_reg;
                    wb_rd_reg       <= op_rd_reg;
                    wait_cnt_reg    <= '0;
                end else begin
                    wait_cnt_reg    <= wait_cnt_reg + CNT_W'(1);
                    wb_valid_reg    <= 1'b0;
                    wb_w_enable_reg <= 1'b0;
                end
            end
        end
    end

    assign dmem_we     = dmem_we_reg;
    assign dmem_addr   = dmem_addr_reg;
    assign dmem_be     = dmem_be_reg;
    assign dmem_wdata  = dmem_wdata_reg;
    assign wb_valid    = wb_valid_reg;
    assign wb_pc       = wb_pc_reg;
    assign wb_rd_addr  = wb_rd_reg;
    assign wb_data     = wb_data_reg;
    assign wb_w_enable = wb_w_enable_reg;
    assign bus_err     = bus_err_reg;
    assign misalign    = misalign_reg;
endmodule

// File: tb/tb_memory_access.sv
// Scoreboard bench for memory_access: directed ops, a latency-programmable memory responder and a monitor.
module tb_memory_access;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_w_enable, in_is_store, in_is_load, in_is_load_unsigned;
    logic [31:0] in_pc, in_alu_result, in_w_data;
    logic [1:0]  in_width;
    logic [4:0]  in_rd_addr;
    logic        stall, dmem_req, dmem_we, dmem_ack;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_be;
    logic        wb_valid, wb_w_enable, bus_err, misalign;
    logic [31:0] wb_pc, wb_data;
    logic [4:0]  wb_rd_addr;

    always #5 clk = ~clk;

    memory_access #(.MAX_WAIT(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_pc(in_pc),
        .in_alu_result(in_alu_result), .in_w_data(in_w_data), .in_width(in_width),
        .in_rd_addr(in_rd_addr), .in_w_enable(in_w_enable), .in_is_store(in_is_store),
        .in_is_load(in_is_load), .in_is_load_unsigned(in_is_load_unsigned),
        .stall(stall), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_be(dmem_be), .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack),
        .dmem_rdata(dmem_rdata), .wb_valid(wb_valid), .wb_pc(wb_pc),
        .wb_rd_addr(wb_rd_addr), .wb_data(wb_data), .wb_w_enable(wb_w_enable),
        .bus_err(bus_err), .misalign(misalign)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  rd;
        logic [31:0] data;
        logic        we;
        logic        err;
        logic        mis;
    } wb_t;
    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic        we;
    } req_t;

    wb_t  wb_q[$];
    req_t req_q[$];
    int   checks = 0;
    int   errors = 0;
    int   ack_delay = 0;
    int   req_cycles = 0;
    logic [31:0] mem_rdata = '0;
    logic prev_req = 1'b0;

    // Memory responder: acks on the ack_delay-th request cycle, never when negative.
    initial begin dmem_ack = 1'b0; dmem_rdata = '0; end
    always @(posedge clk) begin
        if (dmem_req) begin
            if (ack_delay >= 0 && req_cycles == ack_delay) begin
                dmem_ack = 1'b1; dmem_rdata = mem_rdata;
            end else begin
                dmem_ack = 1'b0; dmem_rdata = '0;
            end
            req_cycles++;
        end else begin
            dmem_ack = 1'b0; req_cycles = 0;
        end
    end

    always @(posedge clk) begin
        #2;
        if (dmem_req && !prev_req) begin
            req_t got, exp;
            checks++;
            got = '{addr: dmem_addr, be: dmem_be, wdata: dmem_wdata, we: dmem_we};
            if (req_q.size() == 0) begin
                errors++;
                $display("FAIL req_unexpected: got addr=%h be=%b wdata=%h we=%b, required none",
                         dmem_addr, dmem_be, dmem_wdata, dmem_we);
            end else begin
                exp = req_q.pop_front();
                if (got !== exp) begin
                    errors++;
                    $display("FAIL req: got addr=%h be=%b wdata=%h we=%b, required addr=%h be=%b wdata=%h we=%b",
                             got.addr, got.be, got.wdata, got.we, exp.addr, exp.be, exp.wdata, exp.we);
                end else
                    $display("req ok: addr=%h be=%b wdata=%h we=%b", got.addr, got.be, got.wdata, got.we);
            end
        end
        prev_req = dmem_req;
        if (wb_valid) begin
            wb_t got, exp;
            checks++;
            got = '{pc: wb_pc, rd: wb_rd_addr, data: wb_data, we: wb_w_enable, err: bus_err, mis: misalign};
            if (wb_q.size() == 0) begin
                errors++;
                $display("FAIL wb_unexpected: got pc=%h data=%h, required no write-back", wb_pc, wb_data);
            end else begin
                exp = wb_q.pop_front();
                if (got !== exp) begin
                    errors++;
                    $display("FAIL wb: got pc=%h rd=%0d data=%h we=%b err=%b mis=%b, required pc=%h rd=%0d data=%h we=%b err=%b mis=%b",
                             got.pc, got.rd, got.data, got.we, got.err, got.mis,
                             exp.pc, exp.rd, exp.data, exp.we, exp.err, exp.mis);
                end else
                    $display("wb ok: pc=%h rd=%0d data=%h we=%b err=%b mis=%b",
                             got.pc, got.rd, got.data, got.we, got.err, got.mis);
            end
        end else if (bus_err || misalign) begin
            checks++; errors++;
            $display("FAIL pulse_without_wb: got bus_err=%b misalign=%b, required 0 0", bus_err, misalign);
        end
    end

    task automatic push_wb(input logic [31:0] pc, input logic [4:0] rd, input logic [31:0] data,
                           input logic we, input logic err, input logic mis);
        wb_q.push_back('{pc: pc, rd: rd, data: data, we: we, err: err, mis: mis});
    endtask

    task automatic push_req(input logic [31:0] addr, input logic [3:0] be,
                            input logic [31:0] wdata, input logic we);
        req_q.push_back('{addr: addr, be: be, wdata: wdata, we: we});
    endtask

    task automatic drive(input logic [31:0] pc, input logic [31:0] alu, input logic [31:0] wd,
                         input logic [1:0] w, input logic [4:0] rd, input logic we,
                         input logic st, input logic ld, input logic uns);
        in_valid = 1'b1; in_pc = pc; in_alu_result = alu; in_w_data = wd; in_width = w;
        in_rd_addr = rd; in_w_enable = we; in_is_store = st; in_is_load = ld;
        in_is_load_unsigned = uns;
    endtask

    // Presents one op and holds it until stall drops, counting stalled cycles.
    task automatic issue(input string name, input logic [31:0] pc, input logic [31:0] alu,
                         input logic [31:0] wd, input logic [1:0] w, input logic [4:0] rd,
                         input logic we, input logic st, input logic ld, input logic uns,
                         input int exp_stall);
        int n = 0;
        @(posedge clk);
        drive(pc, alu, wd, w, rd, we, st, ld, uns);
        #2;
        while (stall && n < 50) begin
            n++;
            @(posedge clk); #2;
        end
        checks++;
        if (n != exp_stall) begin
            errors++;
            $display("FAIL stall_%s: got %0d stall cycles, required %0d", name, n, exp_stall);
        end else
            $display("stall ok %s: %0d cycles", name, n);
    endtask

    task automatic idle(input int cycles);
        repeat (cycles) begin
            @(posedge clk);
            in_valid = 1'b0; in_is_load = 1'b0; in_is_store = 1'b0;
        end
    endtask

    initial begin
        rst = 1'b0;
        in_valid = 0; in_pc = 0; in_alu_result = 0; in_w_data = 0; in_width = 0;
        in_rd_addr = 0; in_w_enable = 0; in_is_store = 0; in_is_load = 0; in_is_load_unsigned = 0;
        #2;
        checks++;
        if ({stall, dmem_req, wb_valid, wb_w_enable, bus_err, misalign, dmem_we} !== 7'd0 ||
            dmem_be !== 4'd0 || wb_data !== 32'd0 || dmem_addr !== 32'd0) begin
            errors++;
            $display("FAIL reset_state: got stall=%b req=%b wb_valid=%b be=%b wb_data=%h, required all 0",
                     stall, dmem_req, wb_valid, dmem_be, wb_data);
        end else
            $display("reset ok");
        @(posedge clk); rst = 1'b1;

        // word load, immediate ack
        ack_delay = 0; mem_rdata = 32'hDEADBEEF;
        push_req(32'h100, 4'b1111, 32'h0, 1'b0);
        push_wb(32'h1000, 5'd1, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0);
        issue("word_load", 32'h1000, 32'h100, 32'h0, 2'd2, 5'd1, 1'b1, 1'b0, 1'b1, 1'b0, 1);
        idle(1);

        // signed and unsigned byte loads from the top lane
        mem_rdata = 32'h80123456;
        push_req(32'h100, 4'b1000, 32'h0, 1'b0);
        push_wb(32'h1004, 5'd2, 32'hFFFFFF80, 1'b1, 1'b0, 1'b0);
        issue("lb", 32'h1004, 32'h103, 32'h0, 2'd0, 5'd2, 1'b1, 1'b0, 1'b1, 1'b0, 1);
        push_req(32'h100, 4'b1000, 32'h0, 1'b0);
        push_wb(32'h1008, 5'd3, 32'h00000080, 1'b1, 1'b0, 1'b0);
        issue("lbu", 32'h1008, 32'h103, 32'h0, 2'd0, 5'd3, 1'b1, 1'b0, 1'b1, 1'b1, 1);
        idle(1);

        // half store in upper half, w_enable set but must not write back
        push_req(32'h200, 4'b1100, 32'hABCDABCD, 1'b1);
        push_wb(32'h100C, 5'd4, 32'h0, 1'b0, 1'b0, 1'b0);
        issue("sh", 32'h100C, 32'h202, 32'h0000ABCD, 2'd1, 5'd4, 1'b1, 1'b1, 1'b0, 1'b0, 1);

        // signed half load with two wait cycles
        ack_delay = 2; mem_rdata = 32'h80011234;
        push_req(32'h100, 4'b1100, 32'h0, 1'b0);
        push_wb(32'h1010, 5'd6, 32'hFFFF8001, 1'b1, 1'b0, 1'b0);
        issue("lh_wait2", 32'h1010, 32'h102, 32'h0, 2'd1, 5'd6, 1'b1, 1'b0, 1'b1, 1'b0, 3);

        // ALU op immediately after the load completes
        push_wb(32'h1014, 5'd5, 32'h55, 1'b1, 1'b0, 1'b0);
        issue("alu_b2b", 32'h1014, 32'h55, 32'h0, 2'd2, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 0);
        push_wb(32'h1018, 5'd7, 32'h1234, 1'b0, 1'b0, 1'b0);
        issue("alu_nowe", 32'h1018, 32'h1234, 32'h0, 2'd2, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        idle(2);

        // load and store both set: byte store, lane 1
        ack_delay = 0;
        push_req(32'h300, 4'b0010, 32'h77777777, 1'b1);
        push_wb(32'h101C, 5'd8, 32'h0, 1'b0, 1'b0, 1'b0);
        issue("ld_st_both", 32'h101C, 32'h301, 32'h12345677, 2'd0, 5'd8, 1'b1, 1'b1, 1'b1, 1'b0, 1);
        idle(1);

        // timeout: 8 wait cycles without ack plus the issue cycle
        ack_delay = -1;
        push_req(32'h400, 4'b1111, 32'h0, 1'b0);
        push_wb(32'h1020, 5'd9, 32'h0, 1'b0, 1'b1, 1'b0);
        issue("timeout", 32'h1020, 32'h400, 32'h0, 2'd2, 5'd9, 1'b1, 1'b0, 1'b1, 1'b0, 9);
        idle(2);

        // word load at a misaligned address
        ack_delay = 0; mem_rdata = 32'hCAFEF00D;
`ifdef MISALIGN_TRAP_EN
        push_wb(32'h1024, 5'd10, 32'h0, 1'b0, 1'b0, 1'b1);
        issue("lw_misalign", 32'h1024, 32'h101, 32'h0, 2'd2, 5'd10, 1'b1, 1'b0, 1'b1, 1'b0, 0);
`else
        push_req(32'h100, 4'b1111, 32'h0, 1'b0);
        push_wb(32'h1024, 5'd10, 32'hCAFEF00D, 1'b1, 1'b0, 1'b0);
        issue("lw_misalign", 32'h1024, 32'h101, 32'h0, 2'd2, 5'd10, 1'b1, 1'b0, 1'b1, 1'b0, 1);
`endif
        idle(1);

        // reset in the middle of a wait: access aborted, nothing written back
        ack_delay = -1;
        push_req(32'h500, 4'b1111, 32'h0, 1'b0);
        @(posedge clk);
        drive(32'h1028, 32'h500, 32'h0, 2'd2, 5'd11, 1'b1, 1'b0, 1'b1, 1'b0);
        repeat (3) @(posedge clk);
        #2; rst = 1'b0; #1;
        checks++;
        if ({dmem_req, stall, wb_valid} !== 3'b000) begin
            errors++;
            $display("FAIL reset_mid_wait: got req=%b stall=%b wb_valid=%b, required 0 0 0",
                     dmem_req, stall, wb_valid);
        end else
            $display("reset mid-wait ok");
        @(posedge clk); in_valid = 1'b0; in_is_load = 1'b0;
        @(posedge clk); rst = 1'b1;
        idle(6);

        checks++;
        if (wb_q.size() != 0 || req_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d wb and %0d req pending, required 0 0", wb_q.size(), req_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/memory_access.md
MEMORY_ACCESS -- requirements
Module: memory_access

Interface
REQ-001 Parameter MAX_WAIT, default 8: max cycles in WAIT without dmem_ack before bus error.
REQ-002 clk  in  1  pipeline clock; all registers update on falling edge, same as neighbouring stages.
REQ-003 rst  in  1  asynchronous, active-low reset.
REQ-004 in_valid in 1; in_pc in 32; in_alu_result in 32 (address or result); in_w_data in 32 (store data); in_width in 2 (0 byte, 1 half, 2 word, 3 treated as word); in_rd_addr in 5; in_w_enable in 1; in_is_store in 1; in_is_load in 1; in_is_load_unsigned in 1: execute-stage pipe register.
REQ-005 stall  out  1  upstream holds all in_* while high; upstream advances only on edges where stall is low.
REQ-006 dmem_req out 1; dmem_we out 1; dmem_addr out 32 (word-aligned, bits[1:0]=0); dmem_be out 4; dmem_wdata out 32: data-memory request, all held stable while dmem_req high.
REQ-007 dmem_ack  in  1  request completes on the edge where dmem_req and dmem_ack are both high; dmem_rdata  in  32  valid with ack.
REQ-008 wb_valid out 1; wb_pc out 32; wb_rd_addr out 5; wb_data out 32; wb_w_enable out 1: write-back pipe register.
REQ-009 bus_err  out  1  one-cycle pulse on timeout; misalign  out  1  one-cycle pulse (tied 0 without MISALIGN_TRAP_EN).

Function
REQ-010 FSM states: IDLE, WAIT; mem op = in_valid and (in_is_load or in_is_store).
REQ-011 IDLE, non-mem op or in_valid=0: next edge loads wb_* with wb_data=in_alu_result, wb_valid=in_valid, wb_w_enable=in_w_enable and in_valid; latency 1.
REQ-012 IDLE, mem op: stall high combinationally; next edge latches dmem_addr/be/wdata/we and the op's pc/rd/width/sign flags, enters WAIT, wb_valid=0.
REQ-013 WAIT: dmem_req=1; stall = not dmem_ack; wait counter increments each edge without ack.
REQ-014 WAIT with ack: next edge loads wb_* from the latched op, wb_valid=1, state to IDLE, counter cleared; minimum load/store latency 2 edges.
REQ-015 Store completion: wb_w_enable=0, wb_data=0; load completion: wb_w_enable=latched w_enable.
REQ-016 Timeout: counter reaching MAX_WAIT without ack -> stall low in that cycle; next edge: bus_err=1, wb_valid=1, wb_w_enable=0, state IDLE.
REQ-017 Ack in the same cycle as the timeout condition: ack wins, no bus_err.
REQ-018 Byte lanes, off=in_alu_result[1:0]: byte be=0001<<off, wdata={4{w_data[7:0]}}; half be=0011<<off, wdata={2{w_data[15:0]}}; word be=1111, wdata=w_data.
REQ-019 Load data = dmem_rdata>>(8*off), truncated to width, zero-extended if is_load_unsigned else sign-extended to 32 bits; word never extended.
REQ-020 dmem_we=in_is_store; in_is_load and in_is_store both set treated as store.
REQ-021 New mem op while in WAIT is impossible (stall held); inputs are ignored in WAIT.

Reset
REQ-022 rst low asynchronously forces IDLE, counter 0, dmem_req 0, stall 0, and every wb_*, dmem_*, bus_err, misalign to 0.
REQ-023 Reset during WAIT aborts the access; no write-back is produced for it after reset release.

Configuration
REQ-024 Macro MISALIGN_TRAP_EN defined: half with off[0]=1 or word with off!=0 in IDLE issues no request, no stall; next edge: misalign=1, wb_valid=1, wb_w_enable=0.
REQ-025 Macro undefined: misalign tied 0; half uses off[1] only (off[0] ignored), word uses off=0; access proceeds normally.

Verification
REQ-026 Word load addr 0x100, ack 1st WAIT cycle, rdata 0xDEADBEEF -> stall 1 cycle, wb_valid at edge 2, wb_data 0xDEADBEEF.
REQ-027 Signed byte load addr 0x103, rdata 0x80123456 -> dmem_be 1000 on load only as addr 0x100, wb_data 0xFFFFFF80; unsigned -> 0x00000080.
REQ-028 Half store addr 0x202, w_data 0x0000ABCD -> dmem_addr 0x200, be 1100, wdata 0xABCDABCD, we 1, wb_w_enable 0.
REQ-029 Word load, ack never asserted, MAX_WAIT=8 -> stall released after 8 WAIT cycles, bus_err pulse 1 cycle, wb_w_enable 0.
REQ-030 ALU op result 0x55 rd 5 back-to-back after a load -> no stall, wb_data 0x55 one edge later; rst low mid-WAIT -> dmem_req 0 immediately, no wb_valid.
REQ-031 With MISALIGN_TRAP_EN, word load addr 0x101 -> dmem_req stays 0, misalign pulse, wb_w_enable 0; without it -> dmem_addr 0x100, normal load.
